// File: rtl/tone_sequencer.sv
// Note-playback engine: plays one accepted note as a square wave for its duration
// (timed by the 1 ms input), then inserts a fixed silent gap before reporting done.
module tone_sequencer #(
    parameter int HALF_W = 18,
    parameter int DUR_W  = 12,
    parameter int GAP_MS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_1ms,
    input  logic              stop,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [HALF_W-1:0] note_half,
    input  logic [DUR_W-1:0]  note_dur,
    output logic              buzzer,
    output logic              busy,
    output logic              note_done,
    output logic [1:0]        dbg_state
);

    localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [MS_W-1:0] GAP_LAST = MS_W'(GAP_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_clk_1ms_q;
    logic [HALF_W-1:0] r_half_q, w_half_nxt;
    logic [HALF_W-1:0] r_tone_cnt, w_tone_nxt;
    logic [DUR_W-1:0]  r_dur_q, w_dur_nxt;
    logic [MS_W-1:0]   r_ms_cnt, w_ms_nxt;
    logic              r_buzzer, w_buzzer_nxt;
    logic              r_note_done, w_done_nxt;

    logic              w_ms_tick;
    logic              w_accept;
    logic              w_tone_wrap;
    logic              w_play_last;
    logic              w_gap_last;
    logic [MS_W-1:0]   w_dur_last;

    // Handshake: a note transfers on any cycle where note_valid and note_ready are both
    // high; note_ready is high only in IDLE with stop low, so stop always wins.
    assign note_ready  = (r_state == ST_IDLE) & ~stop;
    assign w_accept    = note_valid & note_ready;

    assign w_ms_tick   = clk_1ms & ~r_clk_1ms_q;
    assign w_dur_last  = MS_W'(r_dur_q) - MS_W'(1);
    assign w_play_last = w_ms_tick & (r_ms_cnt == w_dur_last);
    assign w_gap_last  = w_ms_tick & (r_ms_cnt == GAP_LAST);
    assign w_tone_wrap = (r_tone_cnt == (r_half_q - HALF_W'(1)));

    always_comb begin
        w_state_nxt  = r_state;
        w_half_nxt   = r_half_q;
        w_dur_nxt    = r_dur_q;
        w_tone_nxt   = r_tone_cnt;
        w_ms_nxt     = r_ms_cnt;
        w_buzzer_nxt = r_buzzer;
        w_done_nxt   = 1'b0;

        if (stop) begin
            w_state_nxt  = ST_IDLE;
            w_tone_nxt   = '0;
            w_ms_nxt     = '0;
            w_buzzer_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_half_nxt   = note_half;
                        w_dur_nxt    = note_dur;
                        w_tone_nxt   = '0;
                        w_ms_nxt     = '0;
                        w_buzzer_nxt = 1'b0;
                        if (note_dur == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    // A zero half-period is a rest: keep the pin low for the whole note.
                    if (r_half_q == '0) begin
                        w_buzzer_nxt = 1'b0;
                        w_tone_nxt   = '0;
                    end else if (w_tone_wrap) begin
                        w_buzzer_nxt = ~r_buzzer;
                        w_tone_nxt   = '0;
                    end else begin
                        w_tone_nxt = r_tone_cnt + HALF_W'(1);
                    end
                    if (w_ms_tick) begin
                        if (w_play_last) begin
                            w_buzzer_nxt = 1'b0;
                            w_tone_nxt   = '0;
                            w_ms_nxt     = '0;
                            if (GAP_MS > 0) begin
                                w_state_nxt = ST_GAP;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_ms_nxt = r_ms_cnt + MS_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    w_buzzer_nxt = 1'b0;
                    if (w_ms_tick) begin
                        if (w_gap_last) begin
                            w_state_nxt = ST_IDLE;
                            w_ms_nxt    = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_ms_nxt = r_ms_cnt + MS_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_buzzer_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_clk_1ms_q <= 1'b0;
            r_half_q    <= '0;
            r_dur_q     <= '0;
            r_tone_cnt  <= '0;
            r_ms_cnt    <= '0;
            r_buzzer    <= 1'b0;
            r_note_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_1ms_q <= clk_1ms;
            r_half_q    <= w_half_nxt;
            r_dur_q     <= w_dur_nxt;
            r_tone_cnt  <= w_tone_nxt;
            r_ms_cnt    <= w_ms_nxt;
            r_buzzer    <= w_buzzer_nxt;
            r_note_done <= w_done_nxt;
        end
    end

    assign buzzer    = r_buzzer;
    assign note_done = r_note_done;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule
